iob_ctls_pack: RTL and testbench

Run-length expander and word packer. It is the inverse of the count-trailing/leading-symbols encoder. Each accepted count C produces C copies of SYMBOL followed by one terminator bit (~SYMBOL), and the resulting bit stream is packed into W-bit output words. Feeding each output word back into the counting encoder, one run at a time, recovers the original counts. The block sits on serializer/decompression paths that rebuild symbol-run bitmaps from count streams.

---
 rtl/iob_ctls_pack_if.sv | 27 ++
 rtl/iob_ctls_pack.sv | 89 ++++++++
 tb/tb_iob_ctls_pack.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/iob_ctls_pack_if.sv
// Count-in / word-out bus of the run-length expander and packer.
// Handshakes: a transfer completes on a rising clock edge where valid and ready are both high (and cke is high).
interface iob_ctls_pack_if #(
    parameter int W = 21
);
    localparam int CW = $clog2(W) + 1;
    localparam int LW = $clog2(2 * W) + 1;

    logic          count_valid_i;
    logic [CW-1:0] count_i;
    logic          count_ready_o;
    logic          flush_i;
    logic          data_valid_o;
    logic [W-1:0]  data_o;
    logic          data_ready_i;
    logic [LW-1:0] level_o;

    modport slave (
        input  count_valid_i, count_i, flush_i, data_ready_i,
        output count_ready_o, data_valid_o, data_o, level_o
    );

    modport master (
        output count_valid_i, count_i, flush_i, data_ready_i,
        input  count_ready_o, data_valid_o, data_o, level_o
    );
endinterface

// File: rtl/iob_ctls_pack.sv
// Run-length expander: each count becomes a run of SYMBOL bits plus a ~SYMBOL terminator,
// and the resulting bit stream is packed into W-bit words.
module iob_ctls_pack #(
    parameter int W      = 21,
    parameter int MODE   = 0,
    parameter int SYMBOL = 0
) (
    input logic           clk_i,
    input logic           cke_i,
    input logic           arst_i,
    iob_ctls_pack_if.slave bus
);
    localparam int CW = $clog2(W) + 1;
    localparam int LW = $clog2(2 * W) + 1;
    localparam int BW = 2 * W;
    localparam logic          SYM = SYMBOL[0];
    localparam logic [LW-1:0] W_L = LW'(W);
    localparam logic [CW-1:0] W_C = CW'(W);

    logic [BW-1:0] buffer;
    logic [LW-1:0] level;
    logic          flush_pend;

    logic          ready;
    logic          valid;
    logic          push;
    logic          pop;
    logic [CW-1:0] c_sat;
    logic [LW-1:0] run_len;
    logic [LW-1:0] base;
    logic [LW-1:0] level_upd;
    logic [BW-1:0] shifted;
    logic [BW-1:0] term_mask;
    logic [BW-1:0] appended;

    assign ready = (level <= W_L) && !flush_pend;
    assign valid = (level >= W_L);

    // Bits at and above level are always SYMBOL, so appending a run only has to
    // place its single terminator bit; padding needs no buffer write at all.
    always_comb begin
        c_sat     = (bus.count_i > W_C) ? W_C : bus.count_i;
        run_len   = (c_sat == W_C) ? W_L : LW'(c_sat) + LW'(1);
        push      = bus.count_valid_i && ready && cke_i;
        pop       = valid && bus.data_ready_i && cke_i;
        base      = pop ? (level - W_L) : level;
        shifted   = pop ? {{W{SYM}}, buffer[BW-1:W]} : buffer;
        term_mask = '0;
        if (push && (c_sat != W_C)) begin
            term_mask = BW'(1) << (base + LW'(c_sat));
        end
        appended  = SYM ? (shifted & ~term_mask) : (shifted | term_mask);
        level_upd = base + (push ? run_len : '0);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            buffer     <= {BW{SYM}};
            level      <= '0;
            flush_pend <= 1'b0;
        end else if (cke_i) begin
            if (flush_pend && (level != '0) && (level < W_L)) begin
                // Pad out the partial word; no push or pop can occur in this state.
                level      <= W_L;
                flush_pend <= 1'b0;
            end else begin
                buffer     <= appended;
                level      <= level_upd;
                flush_pend <= (flush_pend || bus.flush_i) && (level_upd != '0);
            end
        end
    end

    generate
        if (MODE != 0) begin : g_msb_first
            always_comb begin
                for (int i = 0; i < W; i++) begin
                    bus.data_o[i] = buffer[W-1-i];
                end
            end
        end else begin : g_lsb_first
            assign bus.data_o = buffer[W-1:0];
        end
    endgenerate

    assign bus.count_ready_o = ready;
    assign bus.data_valid_o  = valid;
    assign bus.level_o       = level;
endmodule

// File: tb/tb_iob_ctls_pack.sv
// Bench for iob_ctls_pack (W=8) with three symbol/order variants driven in lockstep,
// checked against a bit-queue model and a run-length decoder of the emitted words.
module tb_iob_ctls_pack;
    localparam int W = 8;

    logic       clk;
    logic       rst;
    logic       ck;
    logic       cv;
    logic [3:0] cnt;
    logic       fl;
    logic       dr;

    int checks   = 0;
    int failures = 0;

    // Model: one entry per buffered bit, 1 = terminator, 0 = run symbol (LSB-first).
    bit  q[$];
    bit  pend_m;
    int  sent_q[$];
    bit  obs_bits[$];
    logic [W-1:0] exp_q[$];

    iob_ctls_pack_if #(.W(W)) if0 ();
    iob_ctls_pack_if #(.W(W)) if1 ();
    iob_ctls_pack_if #(.W(W)) if2 ();

    assign if0.count_valid_i = cv;
    assign if0.count_i       = cnt;
    assign if0.flush_i       = fl;
    assign if0.data_ready_i  = dr;
    assign if1.count_valid_i = cv;
    assign if1.count_i       = cnt;
    assign if1.flush_i       = fl;
    assign if1.data_ready_i  = dr;
    assign if2.count_valid_i = cv;
    assign if2.count_i       = cnt;
    assign if2.flush_i       = fl;
    assign if2.data_ready_i  = dr;

    iob_ctls_pack #(.W(W), .MODE(0), .SYMBOL(0)) dut0 (.clk_i(clk), .cke_i(ck), .arst_i(rst), .bus(if0.slave));
    iob_ctls_pack #(.W(W), .MODE(1), .SYMBOL(0)) dut1 (.clk_i(clk), .cke_i(ck), .arst_i(rst), .bus(if1.slave));
    iob_ctls_pack #(.W(W), .MODE(0), .SYMBOL(1)) dut2 (.clk_i(clk), .cke_i(ck), .arst_i(rst), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] model_word(input int mode, input int sym);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < W; i++) begin
            if (mode != 0) v[W-1-i] = q[i] ^ sym[0];
            else           v[i]     = q[i] ^ sym[0];
        end
        return v;
    endfunction

    task automatic model_reset();
        q.delete();
        pend_m = 1'b0;
    endtask

    // Drive one cycle at the falling edge, check outputs against the model, then advance the model.
    task automatic step(input bit v, input int c, input bit f, input bit r, input bit k);
        int  lvl;
        bit  ready_m;
        bit  valid_m;
        int  cs;
        logic [W-1:0] w;
        cv = v; cnt = 4'(c); fl = f; dr = r; ck = k;
        lvl     = q.size();
        ready_m = (lvl <= W) && !pend_m;
        valid_m = (lvl >= W);
        chk("ready0", 32'(if0.count_ready_o), 32'(ready_m));
        chk("ready2", 32'(if2.count_ready_o), 32'(ready_m));
        chk("valid0", 32'(if0.data_valid_o), 32'(valid_m));
        chk("valid1", 32'(if1.data_valid_o), 32'(valid_m));
        chk("level0", 32'(if0.level_o), 32'(lvl));
        chk("level2", 32'(if2.level_o), 32'(lvl));
        if (valid_m) begin
            chk("data0", 32'(if0.data_o), 32'(model_word(0, 0)));
            chk("data1", 32'(if1.data_o), 32'(model_word(1, 0)));
            chk("data2", 32'(if2.data_o), 32'(model_word(0, 1)));
        end
        if (k) begin
            if (pend_m && lvl > 0 && lvl < W) begin
                while (q.size() < W) q.push_back(1'b0);
                pend_m = 1'b0;
            end else begin
                if (valid_m && r) begin
                    w = if0.data_o;
                    exp_q.push_back(model_word(0, 0));
                    for (int i = 0; i < W; i++) obs_bits.push_back(w[i]);
                    repeat (W) void'(q.pop_front());
                end
                if (v && ready_m) begin
                    cs = (c > W) ? W : c;
                    sent_q.push_back(cs);
                    repeat (cs) q.push_back(1'b0);
                    if (cs < W) q.push_back(1'b1);
                end
                if (f && q.size() != 0) pend_m = 1'b1;
                if (q.size() == 0) pend_m = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int pos;
        int idx;
        int n;
        int rc;
        rst = 1'b1; ck = 1'b1; cv = 1'b0; cnt = '0; fl = 1'b0; dr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", 32'(if0.data_valid_o), 32'd0);
        chk("rst_ready", 32'(if0.count_ready_o), 32'd1);
        chk("rst_level", 32'(if0.level_o), 32'd0);
        chk("rst_data0", 32'(if0.data_o), 32'h00);
        chk("rst_data2", 32'(if2.data_o), 32'hFF);

        // Counts 3,2,0 back to back form exactly one word.
        step(1, 3, 0, 1, 1);
        step(1, 2, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        chk("t1_word_lsb", 32'(if0.data_o), 32'hC8);
        chk("t2_word_msb", 32'(if1.data_o), 32'h13);
        chk("t2_word_ones", 32'(if2.data_o), 32'h37);
        step(0, 0, 0, 1, 1);
        chk("t1_level_after_pop", 32'(if0.level_o), 32'd0);

        // Full-length run, then a short run closed by flush; repeat with a saturating count.
        for (int rep = 0; rep < 2; rep++) begin
            step(1, (rep == 0) ? 8 : 9, 0, 1, 1);
            chk("t3_full_word", 32'(if0.data_o), 32'h00);
            step(1, 3, 0, 1, 1);
            step(0, 0, 1, 1, 1);
            step(0, 0, 0, 1, 1);
            chk("t3_flush_word", 32'(if0.data_o), 32'h08);
            chk("t3_flush_word_ones", 32'(if2.data_o), 32'hF7);
            step(0, 0, 0, 1, 1);
        end

        // Backpressure: two words buffered, then drained on consecutive cycles.
        step(1, 7, 0, 0, 1);
        step(1, 7, 0, 0, 1);
        chk("t4_level16", 32'(if0.level_o), 32'd16);
        chk("t4_ready_low", 32'(if0.count_ready_o), 32'd0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        chk("t4_second_word", 32'(if0.data_o), 32'h80);
        chk("t4_ready_back", 32'(if0.count_ready_o), 32'd1);
        step(0, 0, 0, 1, 1);

        // Simultaneous push and pop at level W.
        step(1, 7, 0, 0, 1);
        step(1, 1, 0, 1, 1);
        chk("t5_level2", 32'(if0.level_o), 32'd2);
        chk("t5_low_bits", 32'(if0.data_o[1:0]), 32'b10);
        step(0, 0, 1, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 1, 1, 1);
        step(0, 0, 0, 1, 1);
        chk("t5_flush_empty", 32'(if0.data_valid_o), 32'd0);
        step(1, 5, 0, 1, 0);
        chk("cke_hold", 32'(if0.level_o), 32'd0);

        // Asynchronous reset with a pending flush.
        step(1, 4, 0, 1, 1);
        step(0, 0, 1, 1, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(if0.data_valid_o), 32'd0);
        chk("t6_rst_level", 32'(if0.level_o), 32'd0);
        chk("t6_rst_ready", 32'(if2.count_ready_o), 32'd1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Random count stream, then decode the emitted words back into counts.
        sent_q.delete();
        obs_bits.delete();
        exp_q.delete();
        repeat (400) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9), 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0);
        end
        pos = 0;
        idx = 0;
        while (1) begin
            n = 0;
            while (n < W && pos + n < obs_bits.size() && obs_bits[pos+n] == 1'b0) n++;
            if (n == W) begin
                rc = W;
                pos += W;
            end else if (pos + n < obs_bits.size()) begin
                rc = n;
                pos += n + 1;
            end else begin
                break;
            end
            if (idx < sent_q.size()) chk("decode_count", 32'(rc), 32'(sent_q[idx]));
            else chk("decode_extra_run", 32'(idx), 32'(sent_q.size() - 1));
            idx++;
        end
        chk("decode_nonempty", 32'(idx > 10), 32'd1);
        chk("words_emitted", 32'(exp_q.size() * W), 32'(obs_bits.size()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
